hazard_stall: RTL and testbench

HAZARD_STALL -- requirements
Module: hazard_stall

---
 rtl/hazard_stall.sv | 147 ++++++++++++++
 tb/tb_hazard_stall.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall.sv
// -----------------------------------------------------------------------------
// hazard_stall
//   Pipeline hazard unit for a 5-stage core with an iterative multiply/divide
//   unit. Detects load-use hazards between E and D, tracks the mult/div unit
//   (IDLE -> BUSY -> DONE) and stalls D instructions that issue to, or read
//   HI/LO from, an occupied unit.
//
//   Parameters
//     MUL_CYCLES   multiply latency in cycles (1..63)
//     DIV_CYCLES   divide latency in cycles   (1..63)
//
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous active-low reset
//     mem_to_reg_e   E instruction is a load
//     write_reg_e    destination register of the E instruction
//     rs_d, rt_d     source registers of the D instruction
//     uses_rs_d/rt_d D instruction actually reads rs / rt
//     kill_d         D instruction is squashed
//     md_start_d     D instruction issues a mult/div
//     md_is_div_d    issue is a divide (1) or multiply (0)
//     md_read_d      D instruction is mfhi/mflo
//     stall_f        hold the PC
//     stall_d        hold the F/D register
//     flush_e        bubble into the D/E register
//     md_busy        mult/div unit occupied (BUSY or DONE)
//     md_done        HI/LO write-back this cycle
//     stall_count    stall statistics counter
//
//   Build option
//     HAZARD_STALL_CNT_EN  when defined, stall_count counts stall_d cycles
//                          (saturating); otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module hazard_stall #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg_e,
    input  logic [4:0]  write_reg_e,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        uses_rs_d,
    input  logic        uses_rt_d,
    input  logic        kill_d,
    input  logic        md_start_d,
    input  logic        md_is_div_d,
    input  logic        md_read_d,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       lu;
    logic       md;
    logic       stall;
    logic       accept;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    always_comb begin
        lu = mem_to_reg_e && (write_reg_e != 5'd0) && !kill_d &&
             ((uses_rs_d && (rs_d == write_reg_e)) ||
              (uses_rt_d && (rt_d == write_reg_e)));
        md = (state_q != IDLE) && (md_start_d || md_read_d) && !kill_d;
        stall  = lu || md;
        // A stalled D instruction retries the issue later, so nothing is
        // started while stall is high.
        accept = md_start_d && !kill_d && !stall && (state_q == IDLE);
    end

    always_comb begin
        stall_f = stall;
        stall_d = stall;
        flush_e = stall;
        md_busy = (state_q != IDLE);
        md_done = (state_q == DONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = md_is_div_d ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 6'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall.sv
module tb_hazard_stall;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic        clk;
    logic        rst;
    logic        mem_to_reg_e;
    logic [4:0]  write_reg_e;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic        uses_rs_d;
    logic        uses_rt_d;
    logic        kill_d;
    logic        md_start_d;
    logic        md_is_div_d;
    logic        md_read_d;
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_stall #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_to_reg_e(mem_to_reg_e),
        .write_reg_e (write_reg_e),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .uses_rs_d   (uses_rs_d),
        .uses_rt_d   (uses_rt_d),
        .kill_d      (kill_d),
        .md_start_d  (md_start_d),
        .md_is_div_d (md_is_div_d),
        .md_read_d   (md_read_d),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_e     (flush_e),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // left = cycles the unit remains occupied: N+1 after an accept
    // (N busy cycles plus the one write-back cycle); write-back when left==1.
    int          left;
    logic [31:0] cnt_m;

    function automatic logic model_lu();
        return mem_to_reg_e && write_reg_e != 0 && !kill_d &&
               ((uses_rs_d && rs_d == write_reg_e) || (uses_rt_d && rt_d == write_reg_e));
    endfunction

    function automatic logic model_stall();
        return model_lu() || (left > 0 && (md_start_d || md_read_d) && !kill_d);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            left  <= 0;
            cnt_m <= 0;
        end else begin
`ifdef HAZARD_STALL_CNT_EN
            if (model_stall() && cnt_m != 32'hFFFF_FFFF) cnt_m <= cnt_m + 1;
`endif
            if (left > 0)
                left <= left - 1;
            else if (md_start_d && !kill_d && !model_stall())
                left <= (md_is_div_d ? DIV_N : MUL_N) + 1;
        end
    end

    always @(negedge clk) begin
        logic s;
        s = model_stall();
        check("stall_f",     {31'd0, stall_f}, {31'd0, s});
        check("stall_d",     {31'd0, stall_d}, {31'd0, s});
        check("flush_e",     {31'd0, flush_e}, {31'd0, s});
        check("md_busy",     {31'd0, md_busy}, {31'd0, left > 0});
        check("md_done",     {31'd0, md_done}, {31'd0, left == 1});
        check("stall_count", stall_count, cnt_m);
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        mem_to_reg_e = 0; write_reg_e = 0; rs_d = 0; rt_d = 0;
        uses_rs_d = 0; uses_rt_d = 0; kill_d = 0;
        md_start_d = 0; md_is_div_d = 0; md_read_d = 0;
    endtask

    task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs);
        mem_to_reg_e = 1; write_reg_e = wr; rs_d = rs; uses_rs_d = 1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && md_busy; i++) @(posedge clk);
        #1;
        check(name, {31'd0, md_busy}, 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int done_pos;
        int stall_n;
        int pulses;

        rst = 0;
        idle_inputs();
        @(negedge clk);
        check("rst_busy",  {31'd0, md_busy}, 32'd0);
        check("rst_done",  {31'd0, md_done}, 32'd0);
        check("rst_count", stall_count, 32'd0);
        set_lu(5'd8, 5'd8);
        #1;
        check("rst_lu_stall", {31'd0, stall_d}, 32'd1);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1;

        // seven load-use stall edges
        set_lu(5'd3, 5'd3);
        repeat (7) @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
`ifdef HAZARD_STALL_CNT_EN
        check("count7", stall_count, 32'd7);
`else
        check("count0", stall_count, 32'd0);
`endif

        // load-use, then register 0 destination
        set_lu(5'd8, 5'd8);
        #1;
        check("lu_f", {31'd0, stall_f}, 32'd1);
        check("lu_d", {31'd0, stall_d}, 32'd1);
        check("lu_e", {31'd0, flush_e}, 32'd1);
        write_reg_e = 0; rs_d = 0;
        #1;
        check("lu_r0", {29'd0, stall_f, stall_d, flush_e}, 32'd0);
        idle_inputs();

        // multiply latency
        @(posedge clk); #1;
        md_start_d = 1; md_is_div_d = 0;
        @(posedge clk); #1;
        md_start_d = 0;
        busy_cnt = 0; done_pos = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (md_busy) busy_cnt++;
            if (md_done) done_pos = done_pos * 10 + k;
        end
        check("mul_busy_cycles", busy_cnt, 32'd5);
        check("mul_done_pos",    done_pos, 32'd5);

        // read after divide
        @(posedge clk); #1;
        md_start_d = 1; md_is_div_d = 1;
        @(posedge clk); #1;
        md_start_d = 0; md_read_d = 1;
        stall_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall_d) stall_n++;
        end
        check("div_read_stalls", stall_n, 32'd33);
        check("div_read_after",  {31'd0, stall_d}, 32'd0);
        idle_inputs();

        // combined hazard in IDLE
        @(posedge clk); #1;
        md_start_d = 1; md_is_div_d = 0;
        set_lu(5'd5, 5'd5);
        @(negedge clk);
        check("comb_stall", {31'd0, stall_d}, 32'd1);
        @(posedge clk); #1;
        check("comb_no_accept", {31'd0, md_busy}, 32'd0);
        mem_to_reg_e = 0;
        @(posedge clk); #1;
        check("comb_accept", {31'd0, md_busy}, 32'd1);
        idle_inputs();
        wait_idle("comb_idle");

        // kill during BUSY, then reset at counter 10
        @(posedge clk); #1;
        md_start_d = 1; md_is_div_d = 1;
        @(posedge clk); #1;
        md_start_d = 0;
        repeat (21) @(posedge clk);
        #1;
        kill_d = 1; md_read_d = 1;
        #1;
        check("kill_no_stall", {31'd0, stall_d}, 32'd0);
        check("kill_busy",     {31'd0, md_busy}, 32'd1);
        rst = 0;
        #1;
        check("abort_busy", {31'd0, md_busy}, 32'd0);
        idle_inputs();
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_done) pulses++;
            if (k == 2) rst = 1;
        end
        check("abort_no_done", pulses, 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst          = ($urandom_range(0, 199) != 0);
            mem_to_reg_e = ($urandom_range(0, 1) == 1);
            write_reg_e  = 5'($urandom_range(0, 3));
            rs_d         = 5'($urandom_range(0, 3));
            rt_d         = 5'($urandom_range(0, 3));
            uses_rs_d    = ($urandom_range(0, 1) == 1);
            uses_rt_d    = ($urandom_range(0, 1) == 1);
            kill_d       = ($urandom_range(0, 9) == 0);
            md_start_d   = ($urandom_range(0, 4) == 0);
            md_is_div_d  = ($urandom_range(0, 3) == 0);
            md_read_d    = ($urandom_range(0, 4) == 0);
        end
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        wait_idle("final_idle");
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
